// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: drives PC counter load/preset/ce and the
// instruction-memory handshake, with run/step/halt, debugger load and fetch timeout.
module pc_sequencer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    input  logic             dbg_load,
    input  logic [WIDTH-1:0] dbg_addr,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_addr,
    input  logic             fetch_ack,
    output logic             fetch_req,
    output logic             ir_strobe,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_preset,
    output logic             pc_ce,
    output logic [2:0]       state,
    output logic             fault
);
    // state  | meaning
    // INIT   | one-shot load of RESET_VEC into the PC
    // IDLE   | stopped; accepts debugger load, run or step
    // FETCH  | fetch_req high, waiting for fetch_ack or timeout
    // EXEC   | IR valid; decoder's jump/jump_addr sampled
    // UPDATE | PC advanced or loaded; decide next fetch or idle
    // FAULT  | fetch timed out; terminal until reset
    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_FETCH  = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic             step_q, step_d;
    logic             req_d, strobe_d, load_d, ce_d, fault_d;
    logic [WIDTH-1:0] preset_d;
    logic             go;

    assign go    = run && !halt;
    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_INIT;
            wait_q    <= '0;
            step_q    <= 1'b0;
            fetch_req <= 1'b0;
            ir_strobe <= 1'b0;
            pc_load   <= 1'b0;
            pc_preset <= '0;
            pc_ce     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            step_q    <= step_d;
            fetch_req <= req_d;
            ir_strobe <= strobe_d;
            pc_load   <= load_d;
            pc_preset <= preset_d;
            pc_ce     <= ce_d;
            fault     <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        step_d   = step_q;
        req_d    = 1'b0;
        strobe_d = 1'b0;
        load_d   = 1'b0;
        ce_d     = 1'b0;
        preset_d = pc_preset;
        fault_d  = fault;
        case (state_q)
            S_INIT: begin
                load_d   = 1'b1;
                preset_d = RESET_VEC;
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                // A load already pulsing blocks a second one so pc_load never stretches.
                if (dbg_load && !pc_load) begin
                    load_d   = 1'b1;
                    preset_d = dbg_addr;
                end else if (go || step) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    wait_d  = '0;
                    step_d  = !go;
                end
            end
            S_FETCH: begin
                if (fetch_ack) begin
                    state_d  = S_EXEC;
                    strobe_d = 1'b1;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                end else begin
                    req_d  = 1'b1;
                    wait_d = wait_q + 1'b1;
                end
            end
            S_EXEC: begin
                state_d = S_UPDATE;
                if (jump) begin
                    load_d   = 1'b1;
                    preset_d = jump_addr;
                end else begin
                    ce_d = 1'b1;
                end
            end
            S_UPDATE: begin
                step_d = 1'b0;
                if (go && !step_q) begin
                    state_d = S_FETCH;
                    req_d   = 1'b1;
                    wait_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios push expected PC-control
// events; a negedge monitor pops and compares them as the DUT emits them.
module tb_pc_sequencer;
    localparam int K_LOAD = 0;
    localparam int K_CE   = 1;
    localparam int K_STR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] val;
    } evt_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       run, step, halt, dbg_load, jump, fetch_ack;
    logic [7:0] dbg_addr, jump_addr;
    logic       fetch_req, ir_strobe, pc_load, pc_ce, fault;
    logic [7:0] pc_preset;
    logic [2:0] state;

    int   tests = 0;
    int   fails = 0;
    evt_t sb[$];

    logic [7:0] pc_m = 8'h00;
    logic [7:0] ack_addr = 8'h00;
    int   cyc = 0;
    int   mem_en = 1, ack_delay = 0, jump_at = -1, str_idx = 0, wcnt = 0;
    int   req_rises = 0, cur_len = 0, last_len = 0;
    int   last_ce_cyc = -1, chk_gap = 0;
    logic prev_req = 1'b0, prev_load = 1'b0, prev_ce = 1'b0, prev_str = 1'b0;

    pc_sequencer #(.WIDTH(8), .RESET_VEC(8'h00), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .halt(halt),
        .dbg_load(dbg_load), .dbg_addr(dbg_addr), .jump(jump), .jump_addr(jump_addr),
        .fetch_ack(fetch_ack), .fetch_req(fetch_req), .ir_strobe(ir_strobe),
        .pc_load(pc_load), .pc_preset(pc_preset), .pc_ce(pc_ce), .state(state),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // PC counter model driven only by the DUT's control pins.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pc_load) pc_m <= pc_preset;
        else if (pc_ce) pc_m <= pc_m + 8'd1;
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] val);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int kind, input logic [7:0] val);
        evt_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d val %0h expected none", kind, val);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || (kind != K_CE && e.val != val)) begin
                fails++;
                $display("FAIL event: got kind %0d val %0h expected kind %0d val %0h",
                         kind, val, e.kind, e.val);
            end
        end
    endtask

    // Memory and decoder model: ack after ack_delay wait cycles, jump on a chosen instruction.
    always @(negedge clk) begin
        if (reset) begin
            fetch_ack = 1'b0;
            jump      = 1'b0;
            wcnt      = 0;
        end else begin
            jump = 1'b0;
            if (ir_strobe) begin
                if (str_idx == jump_at) jump = 1'b1;
                str_idx++;
            end
            if (fetch_req && mem_en != 0) begin
                if (wcnt >= ack_delay) begin
                    fetch_ack = 1'b1;
                    ack_addr  = pc_m;
                end else begin
                    fetch_ack = 1'b0;
                end
                wcnt++;
            end else begin
                fetch_ack = 1'b0;
                if (!fetch_req) wcnt = 0;
            end
        end
    end

    // Monitor: pops expected events and checks pulse invariants.
    always @(negedge clk) begin
        if (!reset) begin
            if (pc_load) pop_chk(K_LOAD, pc_preset);
            if (pc_ce) begin
                pop_chk(K_CE, 8'h00);
                if (chk_gap != 0 && last_ce_cyc >= 0) chk("ce_period", cyc - last_ce_cyc, 3);
                last_ce_cyc = cyc;
            end
            if (ir_strobe) pop_chk(K_STR, ack_addr);
            if (pc_load && pc_ce) begin
                tests++; fails++;
                $display("FAIL load_ce_overlap: got both high expected exclusive");
            end
            if ((pc_load && prev_load) || (pc_ce && prev_ce) || (ir_strobe && prev_str)) begin
                tests++; fails++;
                $display("FAIL double_pulse: got 2-cycle pulse expected 1-cycle");
            end
            if (fetch_req) begin
                if (!prev_req) req_rises++;
                cur_len++;
            end else if (cur_len > 0) begin
                last_len = cur_len;
                cur_len  = 0;
            end
        end else begin
            cur_len = 0;
        end
        prev_req  = fetch_req;
        prev_load = pc_load;
        prev_ce   = pc_ce;
        prev_str  = ir_strobe;
    end

    task automatic wait_strobes(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            @(posedge clk); #2;
            if (ir_strobe) seen++;
        end
        if (seen < n) chk("strobe_timeout", seen, n);
    endtask

    task automatic wait_req(input int budget);
        int ok = 0;
        for (int i = 0; i < budget && ok == 0; i++) begin
            @(posedge clk); #2;
            if (fetch_req) ok = 1;
        end
        if (ok == 0) chk("req_timeout", 0, 1);
    endtask

    initial begin
        int r0;
        reset = 1'b1; run = 0; step = 0; halt = 0; dbg_load = 0;
        dbg_addr = 8'h00; jump_addr = 8'hA0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_req", fetch_req, 0);
        chk("rst_load", pc_load, 0);
        chk("rst_ce", pc_ce, 0);
        chk("rst_fault", fault, 0);
        chk("rst_strobe", ir_strobe, 0);
        chk("rst_preset", pc_preset, 0);

        // Run from reset vector, four sequential instructions.
        push(K_LOAD, 8'h00);
        for (int i = 0; i < 4; i++) begin
            push(K_STR, 8'(i));
            push(K_CE, 8'h00);
        end
        chk_gap = 1;
        @(negedge clk); reset = 1'b0; run = 1'b1;
        wait_strobes(4, 100);
        run = 1'b0;
        repeat (5) @(negedge clk);
        chk_gap = 0;
        chk("run_state", state, 1);
        chk("run_pc", pc_m, 4);
        chk("run_sb_empty", sb.size(), 0);

        // Debugger load to 5, then single step.
        push(K_LOAD, 8'h05);
        @(negedge clk); dbg_addr = 8'h05; dbg_load = 1'b1;
        @(negedge clk); dbg_load = 1'b0;
        push(K_STR, 8'h05);
        push(K_CE, 8'h00);
        r0 = req_rises;
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (8) @(negedge clk);
        chk("step_reqs", req_rises - r0, 1);
        chk("step_state", state, 1);
        chk("step_pc", pc_m, 6);

        // Jump on the third instruction of this run.
        push(K_STR, 8'h06); push(K_CE, 8'h00);
        push(K_STR, 8'h07); push(K_CE, 8'h00);
        push(K_STR, 8'h08); push(K_LOAD, 8'hA0);
        push(K_STR, 8'hA0); push(K_CE, 8'h00);
        jump_at = str_idx + 2;
        @(negedge clk); run = 1'b1;
        wait_strobes(4, 100);
        run = 1'b0;
        repeat (6) @(negedge clk);
        chk("jump_pc", pc_m, 8'hA1);
        chk("jump_sb_empty", sb.size(), 0);

        // Halt raised mid-fetch: current instruction completes, then idle.
        ack_delay = 3;
        push(K_STR, 8'hA1); push(K_CE, 8'h00);
        r0 = req_rises;
        @(negedge clk); run = 1'b1;
        wait_req(20);
        halt = 1'b1;
        repeat (12) @(negedge clk);
        chk("halt_reqs", req_rises - r0, 1);
        chk("halt_state", state, 1);
        chk("halt_pc", pc_m, 8'hA2);
        halt = 1'b0; run = 1'b0;

        // dbg_load and run on the same edge: load wins, fetch follows.
        ack_delay = 0;
        push(K_LOAD, 8'h40); push(K_STR, 8'h40); push(K_CE, 8'h00);
        @(negedge clk); dbg_addr = 8'h40; dbg_load = 1'b1; run = 1'b1;
        @(posedge clk); #1;
        chk("dbg_run_state", state, 1);
        @(negedge clk); dbg_load = 1'b0;
        wait_strobes(1, 50);
        run = 1'b0;
        repeat (6) @(negedge clk);
        chk("dbg_run_pc", pc_m, 8'h41);

        // Ack on the last allowed wait cycle: no fault.
        ack_delay = 14;
        push(K_STR, 8'h41); push(K_CE, 8'h00);
        @(negedge clk); run = 1'b1;
        wait_strobes(1, 60);
        run = 1'b0;
        repeat (6) @(negedge clk);
        chk("late_ack_req_len", last_len, 15);
        chk("late_ack_fault", fault, 0);
        chk("late_ack_pc", pc_m, 8'h42);

        // Withheld ack: timeout fault, inputs ignored afterwards.
        mem_en = 0;
        @(negedge clk); run = 1'b1;
        for (int i = 0; i < 40 && state != 3'd5; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("to_req_len", last_len, 15);
        chk("to_state", state, 5);
        chk("to_fault", fault, 1);
        step = 1'b1; @(negedge clk); step = 1'b0;
        dbg_load = 1'b1; @(negedge clk); dbg_load = 1'b0;
        repeat (5) @(negedge clk);
        chk("fault_hold_state", state, 5);
        chk("fault_hold_flag", fault, 1);
        chk("fault_hold_req", fetch_req, 0);
        reset = 1'b1; run = 1'b0;
        #1;
        chk("fault_clr", fault, 0);
        chk("fault_clr_state", state, 0);

        // Reset during FETCH drops fetch_req asynchronously.
        push(K_LOAD, 8'h00);
        @(negedge clk); reset = 1'b0; run = 1'b1;
        wait_req(20);
        reset = 1'b1;
        #1;
        chk("async_rst_req", fetch_req, 0);
        chk("async_rst_state", state, 0);
        run = 1'b0; mem_en = 1; ack_delay = 0;
        push(K_LOAD, 8'h00);
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("final_state", state, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-fetch sequencer that drives the program counter's control pins (load, preset, count enable) and handshakes with instruction memory.
- Sits between the PC counter, instruction memory and the decoder.
- Provides run/step/halt control, a debugger PC load, and a fetch-timeout fault.
- All outputs are registered, so the counter's async load pin sees only clean single-cycle pulses.

Parameters:
- WIDTH, 8, PC / address width; must match the PC counter.
- RESET_VEC, 0, PC value loaded after reset.
- TIMEOUT, 15, maximum number of cycles fetch_req may stay high without fetch_ack (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; continuous execution while high.
- step  in  1  single-cycle pulse; execute exactly one instruction from IDLE.
- halt  in  1  level; finish the current instruction, then stop in IDLE.
- dbg_load  in  1  single-cycle pulse; load dbg_addr into the PC (honoured in IDLE only).
- dbg_addr  in  WIDTH  debugger PC value.
- jump  in  1  from decoder; sampled in EXEC.
- jump_addr  in  WIDTH  from decoder; sampled in EXEC.
- fetch_ack  in  1  memory has valid instruction data this cycle.
- fetch_req  out  1  instruction fetch request.
- ir_strobe  out  1  one-cycle pulse; IR latches the fetched word.
- pc_load  out  1  to counter load.
- pc_preset  out  WIDTH  to counter preset.
- pc_ce  out  1  to counter ce.
- state  out  3  current state code.
- fault  out  1  sticky fetch-timeout flag.

Behaviour:
- States and encodings: INIT=0, IDLE=1, FETCH=2, EXEC=3, UPDATE=4, FAULT=5.
- Reset (async, immediate):
  - state=INIT; fetch_req, ir_strobe, pc_load, pc_ce, fault = 0; pc_preset=0; wait counter=0.
  - Reset asserted mid-FETCH drops fetch_req without waiting for a clock edge.
- INIT: for one cycle, pc_load=1 and pc_preset=RESET_VEC; then go to IDLE.
- IDLE, priority order:
  - dbg_load → one-cycle pc_load=1 with pc_preset=dbg_addr; stay in IDLE.
  - Otherwise (run & !halt) or step → FETCH, with fetch_req=1 from that edge and wait counter cleared.
  - run and step together behave as run.
  - halt blocks run but not step.
- FETCH:
  - fetch_req is held high.
  - Each edge with fetch_ack=0 increments the wait counter.
  - fetch_ack=1 → EXEC: fetch_req=0 and ir_strobe=1 for exactly one cycle.
  - fetch_ack=0 with wait counter = TIMEOUT-1 → FAULT: fetch_req=0, fault=1.
  - If fetch_ack arrives on the timeout edge, the ack wins.
  - fetch_req is therefore high for at most TIMEOUT cycles.
- EXEC: sample jump and jump_addr, then go to UPDATE.
  - jump=1 → pc_load=1, pc_preset=jump_addr, pc_ce=0 for one cycle.
  - jump=0 → pc_ce=1, pc_load=0 for one cycle.
- UPDATE: go to FETCH if run & !halt and the instruction was not a step; otherwise go to IDLE.
  - A step latched in IDLE is cleared here.
- FAULT: terminal. All strobes stay 0 and fault stays 1 until reset; run, step and dbg_load are ignored.
- Invariants:
  - pc_load and pc_ce are never high together.
  - Each of pc_load, pc_ce and ir_strobe is never high for two consecutive cycles.
  - fetch_ack outside FETCH is ignored.
  - jump outside EXEC is ignored.
  - dbg_load outside IDLE is dropped, not queued.
- Throughput: 3 cycles per instruction with zero-wait memory (FETCH, EXEC, UPDATE), plus 1 per wait state.
- PC wrap-around is the counter's concern; the sequencer is agnostic to PC value.

Test Plan:
- Reset, then run=1, with memory acking 1 cycle after each req → pc_load pulse with preset=0 in cycle 1; then pc_ce pulses every 3 cycles; PC reads 0,1,2,3.
- From IDLE at PC=5, one step pulse, run=0 → exactly one fetch_req and one ir_strobe; PC=6; state returns to 1 and stays there.
- Run with jump=1, jump_addr=8'hA0 on the 3rd instruction → pc_load pulse with pc_preset=A0 and no pc_ce that cycle; next fetch occurs at PC=A0.
- Withhold fetch_ack with TIMEOUT=15 → fetch_req high exactly 15 cycles; then fault=1, state=5; later run and step have no effect; reset clears fault.
- Ack on the 15th wait cycle → no fault; normal EXEC follows.
- In IDLE, dbg_load with dbg_addr=8'h40 and run=1 on the same edge → pc_load with preset 40, state stays 1 that cycle; next edge enters FETCH with PC=40.
- halt asserted mid-FETCH with run=1 → current instruction completes (ir_strobe, pc_ce); state goes to IDLE with no further fetch_req.
- Reset asserted while fetch_req=1 → fetch_req falls before the next clk edge; state=0.
